// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: MEM->WB bus layout, CP0 addresses, exception codes.
// Optional COUNT register selected by WB_CP0_COUNT_EN (see cp0_regfile).
package wb_stage_pkg;

  localparam int MEM_WB_W = 120;

  localparam logic [7:0] CP0_STATUS = 8'h60;
  localparam logic [7:0] CP0_CAUSE  = 8'h68;
  localparam logic [7:0] CP0_EPC    = 8'h70;
  localparam logic [7:0] CP0_COUNT  = 8'h48;

  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // Software-writable bits: STATUS.IM[15:8] and STATUS.EXL[1]; CAUSE.IP[9:8].
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF02;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  typedef struct packed {
    logic        rsvd;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic        overflow;
    logic [31:0] pc;
  } mem_wb_t;

  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/wb_stage_cp0_regfile.sv
// CP0 register file: STATUS/CAUSE/EPC, plus COUNT when WB_CP0_COUNT_EN is defined.
// Reads are combinational and return pre-update values; all writes land at posedge clk.
module cp0_regfile
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wen,
  input  logic [7:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        exc,
  input  logic [4:0]  exccode,
  input  logic [31:0] epc_in,
  input  logic        eret,
  input  logic [7:0]  raddr,
  output logic [31:0] rdata,
  output logic [31:0] epc_out
);

  logic [31:0] status, status_nxt;
  logic [31:0] cause, cause_nxt;
  logic [31:0] epc;

  always_comb begin
    status_nxt = status;
    if (wen && waddr == CP0_STATUS) status_nxt = masked_write(status, wdata, STATUS_WMASK);
    if (exc)       status_nxt[1] = 1'b1;
    else if (eret) status_nxt[1] = 1'b0;
  end

  always_comb begin
    cause_nxt = cause;
    if (wen && waddr == CP0_CAUSE) cause_nxt = masked_write(cause, wdata, CAUSE_WMASK);
    if (exc) cause_nxt[6:2] = exccode;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status <= STATUS_RST;
      cause  <= '0;
      epc    <= '0;
    end else begin
      status <= status_nxt;
      cause  <= cause_nxt;
      if (exc)                            epc <= epc_in;
      else if (wen && waddr == CP0_EPC)   epc <= wdata;
    end
  end

  assign epc_out = epc;

`ifdef WB_CP0_COUNT_EN
  logic [31:0] count;
  logic        tick;

  // COUNT advances on every other clock; a software write restarts the half-rate phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (wen && waddr == CP0_COUNT) begin
      count <= wdata;
      tick  <= 1'b0;
    end else begin
      tick <= ~tick;
      if (tick) count <= count + 32'd1;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_STATUS: rdata = status;
      CP0_CAUSE:  rdata = cause;
      CP0_EPC:    rdata = epc;
`ifdef WB_CP0_COUNT_EN
      CP0_COUNT:  rdata = count;
`endif
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: final RF write data, HI/LO, CP0 exceptions/eret redirect and pipeline cancel.
// Single-cycle, no backpressure; optional CP0 COUNT via WB_CP0_COUNT_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY  = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                WB_valid,
  input  logic [MEM_WB_W-1:0] MEM_WB_bus_r,
  output logic                rf_wen,
  output logic [4:0]          rf_wdest,
  output logic [31:0]         rf_wdata,
  output logic                WB_over,
  output logic [4:0]          WB_wdest,
  output logic [32:0]         exc_bus,
  output logic                cancel,
  output logic [31:0]         WB_pc
);

  mem_wb_t bus;
  assign bus = MEM_WB_bus_r;

  logic unused_rsvd;
  assign unused_rsvd = bus.rsvd;

  logic exc, ret, commit;
  assign exc    = WB_valid & (bus.syscall | bus.overflow);
  assign ret    = WB_valid & bus.eret;
  assign commit = WB_valid & ~exc;

  logic [31:0] hi, lo;
  logic [31:0] cp0_rdata, epc;

  // lo_result only carries data for mult/div, which always write both halves.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (bus.hi_write) hi <= bus.mem_result;
      if (bus.lo_write) lo <= bus.hi_write ? bus.lo_result : bus.mem_result;
    end
  end

  cp0_regfile #(
    .STATUS_RST (STATUS_RST)
  ) u_cp0 (
    .clk     (clk),
    .resetn  (resetn),
    .wen     (commit & bus.mtc0),
    .waddr   (bus.cp0r_addr),
    .wdata   (bus.mem_result),
    .exc     (exc),
    .exccode (bus.overflow ? EXC_OV : EXC_SYS),
    .epc_in  (bus.pc),
    .eret    (ret),
    .raddr   (bus.cp0r_addr),
    .rdata   (cp0_rdata),
    .epc_out (epc)
  );

  logic [31:0] wdata_sel;
  always_comb begin
    wdata_sel = bus.mem_result;
    if (bus.mfhi)      wdata_sel = hi;
    else if (bus.mflo) wdata_sel = lo;
    else if (bus.mfc0) wdata_sel = cp0_rdata;
  end

  assign rf_wen   = WB_valid & bus.rf_wen & ~exc;
  assign rf_wdest = bus.rf_wdest & {5{WB_valid}};
  assign rf_wdata = wdata_sel & {32{WB_valid}};
  assign WB_over  = WB_valid;
  assign WB_wdest = bus.rf_wdest & {5{WB_valid}};
  assign WB_pc    = bus.pc & {32{WB_valid}};
  assign cancel   = exc | ret;

  always_comb begin
    exc_bus = '0;
    if (exc)      exc_bus = {1'b1, EXC_ENTRY};
    else if (ret) exc_bus = {1'b1, epc};
  end

endmodule
